// File: rtl/dist_sq_gen_pkg.sv
// Shared beamforming constants and the delay-path state encoding (package bf_pkg).
package bf_pkg;

  localparam int DSQ_W   = 32;
  localparam int COORD_W = 16;

  // 4-bit so the encoding lines up with the downstream sqrt stage
  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_ZSQ  = 4'd1;
  localparam logic [3:0] ST_DX   = 4'd2;
  localparam logic [3:0] ST_SQ   = 4'd3;
  localparam logic [3:0] ST_SUM  = 4'd4;
  localparam logic [3:0] ST_OUT  = 4'd5;
  localparam logic [3:0] ST_DONE = 4'd6;

  // |d| of a 17-bit difference of two 16-bit coordinates always fits in 16 bits
  function automatic logic [COORD_W-1:0] abs_dx(input logic signed [COORD_W:0] d);
    return COORD_W'(d[COORD_W] ? -d : d);
  endfunction

endpackage

// File: rtl/dist_sq_gen_if.sv
// Request / result bundle between a focal-point source and dist_sq_gen.
interface dist_sq_gen_if;
  import bf_pkg::*;

  logic                      start;
  logic signed [COORD_W-1:0] xf;
  logic [COORD_W-1:0]        zf;
  logic [DSQ_W-1:0]          dsq;
  logic                      dsq_valid;
  logic                      dsq_ready;
  logic [7:0]                elem_idx;
  logic                      busy;
  logic                      done;

  modport master (
    output start, xf, zf, dsq_ready,
    input  dsq, dsq_valid, elem_idx, busy, done
  );

  modport slave (
    input  start, xf, zf, dsq_ready,
    output dsq, dsq_valid, elem_idx, busy, done
  );

endinterface

// File: rtl/dist_sq_gen_square16.sv
// Registered 16x16 unsigned squarer, one-cycle latency, holds while en is low.
module square16
  import bf_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [COORD_W-1:0] a,
  output logic [DSQ_W-1:0]   p
);

  logic [DSQ_W-1:0] p_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q <= '0;
    end else if (en) begin
      p_q <= DSQ_W'(a) * DSQ_W'(a);
    end
  end

  assign p = p_q;

endmodule

// File: rtl/dist_sq_gen.sv
// Squared element-to-focus distance generator, one element per 4 cycles.
// Optional saturation of the 33-bit sum is enabled by defining DIST_SAT_EN.
module dist_sq_gen
  import bf_pkg::*;
#(
  parameter int                        N_ELEM = 64,
  parameter logic signed [COORD_W-1:0] X0     = -16'sd504,
  parameter logic signed [COORD_W-1:0] PITCH  = 16'sd16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  dist_sq_gen_if.slave bus
);

  localparam logic [7:0] LAST_IDX = 8'(N_ELEM - 1);

  logic [3:0]                state_q, state_d;
  logic signed [COORD_W-1:0] xf_q, xf_d;
  logic [COORD_W-1:0]        zf_q, zf_d;
  logic signed [COORD_W-1:0] xe_q, xe_d;
  logic [7:0]                idx_q, idx_d;
  logic [DSQ_W-1:0]          zsq_q, zsq_d;
  logic signed [COORD_W:0]   dx_q, dx_d;
  logic [DSQ_W-1:0]          dsq_q, dsq_d;
  logic                      valid_q, valid_d;

  logic [COORD_W-1:0]        sq_a;
  logic [DSQ_W-1:0]          sq_p;
  logic [DSQ_W-1:0]          sum_out;

  assign sq_a = (state_q == ST_ZSQ) ? zf_q : abs_dx(dx_q);

  square16 u_sq (
    .clk   (clk),
    .reset (reset),
    .en    (enable),
    .a     (sq_a),
    .p     (sq_p)
  );

`ifdef DIST_SAT_EN
  logic [DSQ_W:0] sum;
  assign sum     = {1'b0, sq_p} + {1'b0, zsq_q};
  assign sum_out = sum[DSQ_W] ? '1 : sum[DSQ_W-1:0];
`else
  assign sum_out = sq_p + zsq_q;
`endif

  always_comb begin
    state_d = state_q;
    xf_d    = xf_q;
    zf_d    = zf_q;
    xe_d    = xe_q;
    idx_d   = idx_q;
    zsq_d   = zsq_q;
    dx_d    = dx_q;
    dsq_d   = dsq_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          xf_d    = bus.xf;
          zf_d    = bus.zf;
          xe_d    = X0;
          idx_d   = '0;
          state_d = ST_ZSQ;
        end
      end
      ST_ZSQ: state_d = ST_DX;
      ST_DX: begin
        // zf^2 leaves the squarer during the first DX only; later DX reuse zsq_q
        if (idx_q == '0) zsq_d = sq_p;
        dx_d    = {xf_q[COORD_W-1], xf_q} - {xe_q[COORD_W-1], xe_q};
        state_d = ST_SQ;
      end
      ST_SQ: state_d = ST_SUM;
      ST_SUM: begin
        dsq_d   = sum_out;
        valid_d = 1'b1;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (bus.dsq_ready) begin
          valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 8'd1;
            xe_d    = xe_q + PITCH;
            state_d = ST_DX;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      xf_q    <= '0;
      zf_q    <= '0;
      xe_q    <= '0;
      idx_q   <= '0;
      zsq_q   <= '0;
      dx_q    <= '0;
      dsq_q   <= '0;
      valid_q <= 1'b0;
    end else if (enable) begin
      state_q <= state_d;
      xf_q    <= xf_d;
      zf_q    <= zf_d;
      xe_q    <= xe_d;
      idx_q   <= idx_d;
      zsq_q   <= zsq_d;
      dx_q    <= dx_d;
      dsq_q   <= dsq_d;
      valid_q <= valid_d;
    end
  end

  assign bus.dsq       = dsq_q;
  assign bus.dsq_valid = valid_q;
  assign bus.elem_idx  = idx_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);

endmodule

// File: doc/dist_sq_gen.md
# dist_sq_gen

Generates the squared element-to-focus distance for every transducer element of one focal point, one result per handshake, in element order. Sits directly upstream of the iterative square-root stage in the beamforming delay path: each 32-bit `dsq` word is the value that stage takes on its `din` input. A shared squaring unit is reused across cycles, so one element is produced every 4 cycles plus any back-pressure.

## Interface
- `N_ELEM`, 64: number of elements per focal point, 1..256.
- `X0`, -16'sd504: signed x position of element 0, lateral units.
- `PITCH`, 16'sd16: signed x step between adjacent elements.
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  clock enable; when low, all state and outputs hold.
- `start`  in  1  single-cycle request to begin a focal point; sampled only in IDLE.
- `xf`  in  16  signed focal x, captured when `start` is accepted.
- `zf`  in  16  unsigned focal depth, captured when `start` is accepted.
- `dsq`  out  32  squared distance, (xf − xe)² + zf².
- `dsq_valid`  out  1  `dsq` holds a result.
- `dsq_ready`  in  1  consumer accepts `dsq`.
- `elem_idx`  out  8  index of the element that `dsq` belongs to.
- `busy`  out  1  high from `start` acceptance through DONE.
- `done`  out  1  one-cycle pulse after the last element's handshake.

## Operation
- States: IDLE, ZSQ, DX, SQ, SUM, OUT, DONE.
- **IDLE**
  - On `start` with `enable` high, capture `xf` and `zf`, set xe = X0, set idx = 0, and go to ZSQ.
  - Otherwise remain in IDLE.
- **ZSQ**: zsq_r (32b) = zf², computed once per focal point. Go to DX.
- **DX**: dx_r (17b signed) = sign-extended xf − sign-extended xe. Go to SQ.
- **SQ**: sq_r (32b) = dx_r², computed by the same squaring unit (operand is |dx_r|, at most 65535). Go to SUM.
- **SUM**: sum (33b) = sq_r + zsq_r. `dsq` gets sum[31:0], or the saturated value under the macro. Assert `dsq_valid` and go to OUT.
- **OUT**
  - Hold `dsq`, `elem_idx` and `dsq_valid` stable until `dsq_valid && dsq_ready` at a rising edge.
  - On that handshake, drop `dsq_valid`.
  - If idx == N_ELEM−1, go to DONE.
  - Otherwise increment idx, set xe += PITCH (16-bit wrap), and go to DX. zsq_r is reused.
- **DONE**: pulse `done` for one cycle and go to IDLE.
- `start` received while `busy` is high is ignored and not queued.
- `xf` and `zf` changing after capture has no effect.
- `busy` is combinationally (state != IDLE).
- Reset values: `dsq` = 0, `dsq_valid` = 0, `elem_idx` = 0, `busy` = 0, `done` = 0, state = IDLE, all internal registers 0.
- Reset mid-operation aborts the focal point immediately, with no `done` pulse.

## Timing
- First result: `start` is sampled at edge E. `dsq_valid` is high after edge E+4.
- Subsequent results: handshake at edge H. `dsq_valid` drops after H and is high again after H+3.
- With `dsq_ready` tied high, results are produced every 4 cycles. A full focal point takes 4·N_ELEM + 2 cycles from `start` to `done`.
- `done` is high in the cycle after the last handshake.
- `enable` low freezes the FSM, including OUT. A handshake only counts on an edge where `enable` is high.
- `dsq_ready` is sampled only in OUT.

## Configuration
- `DIST_SAT_EN` defined: if sum[32] is set, `dsq` = 32'hFFFF_FFFF.
- `DIST_SAT_EN` undefined: `dsq` = sum[31:0], which wraps modulo 2³².
- Overflow is possible only when |dx| is large and zf is large at the same time.

## Structure
- Shared package `bf_pkg` holds:
  - the state encoding localparams (IDLE=0 … DONE=6, 4-bit, matching the width of the downstream stage's state);
  - the `DSQ_W` = 32 and `COORD_W` = 16 constants.
- One sub-module, `square16`: a registered 16×16 unsigned squarer with a 1-cycle latency and a 32-bit result. It is instantiated once and muxed between zf (ZSQ) and |dx_r| (SQ).

## Test plan
- **Basic geometry**: N_ELEM=4, X0=0, PITCH=3, xf=0, zf=4, `dsq_ready`=1 → `dsq` = 16, 25, 52, 97 with `elem_idx` 0..3. `done` fires 18 cycles after `start`.
- **Back-pressure**: hold `dsq_ready`=0 for 10 cycles in OUT → `dsq` and `elem_idx` stay stable and `dsq_valid` stays high. Exactly one transfer occurs once ready rises.
- **Saturation**: xf=32767, X0=−32768, zf=65535, element 0.
  - With `DIST_SAT_EN`: `dsq` = 32'hFFFF_FFFF.
  - Without it: `dsq` = (65535² + 65535²) mod 2³² = 32'hFFFC_0002.
- **Ignored start**: pulse `start` with new xf/zf mid-sweep → the sweep results are unchanged and only one `done` pulse is produced.
- **Reset mid-operation**: assert `reset` while in SQ → outputs clear immediately with no `done`. A following `start` restarts from `elem_idx` 0.
- **Enable gating**: drop `enable` for 5 cycles during SUM → the cycle counts shift by exactly 5 and the values are unchanged.
